// File: rtl/retry_inorder_replay_pkg.sv
// Purpose: shared types for the go-back-N replay buffer and its future pipeline-end partner.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
// Contents: retry_cnt_t, ptr_t, retry_req_t (commit/retry request), retry_ev_e, width helpers.
package retry_pkg;

    localparam int unsigned ID_SIZE_DEF     = 4;
    localparam int unsigned MAX_RETRIES_DEF = 3;

    // Counter must hold the value MaxRetries itself (the "exhausted" state).
    function automatic int unsigned cnt_width(input int unsigned max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

    // Pointers carry one wrap bit above the ID so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned id_size);
        return id_size + 1;
    endfunction

    typedef logic [$clog2(MAX_RETRIES_DEF + 1)-1:0] retry_cnt_t;
    typedef logic [ID_SIZE_DEF:0]                    ptr_t;

    typedef struct packed {
        logic                   commit_vld;
        logic [ID_SIZE_DEF-1:0] commit_id;
        logic                   retry_vld;
        logic [ID_SIZE_DEF-1:0] retry_id;
    } retry_req_t;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_RETRY = 2'd1,
        EV_FAIL  = 2'd2
    } retry_ev_e;

endpackage

// File: rtl/retry_inorder_replay_if.sv
// Purpose: bundles upstream, downstream, commit/retry and status signals of the replay buffer.
// Latency: n/a (wires only).
// Backpressure: ready_o toward upstream, ready_i from downstream; commit/retry are not backpressured.
// Modports: slave = the replay buffer, master = its environment.
interface retry_inorder_replay_if #(
    parameter type         DataType = logic [7:0],
    parameter int unsigned IDSize   = 4
);
    DataType            data_i;
    logic               valid_i;
    logic               ready_o;
    DataType            data_o;
    logic [IDSize-1:0]  id_o;
    logic               valid_o;
    logic               ready_i;
    logic               commit_valid_i;
    logic [IDSize-1:0]  commit_id_i;
    logic               retry_valid_i;
    logic [IDSize-1:0]  retry_id_i;
    logic               retry_ready_o;
    logic               fail_o;
    logic [IDSize-1:0]  fail_id_o;
    logic [IDSize:0]    occupancy_o;

    modport slave (
        input  data_i, valid_i, ready_i, commit_valid_i, commit_id_i, retry_valid_i, retry_id_i,
        output ready_o, data_o, id_o, valid_o, retry_ready_o, fail_o, fail_id_o, occupancy_o
    );

    modport master (
        output data_i, valid_i, ready_i, commit_valid_i, commit_id_i, retry_valid_i, retry_id_i,
        input  ready_o, data_o, id_o, valid_o, retry_ready_o, fail_o, fail_id_o, occupancy_o
    );
endinterface

// File: rtl/retry_inorder_replay_ptrs.sv
// Purpose: head/send/tail pointers, per-head retry counter and fail event of the replay buffer.
// Latency: pointers update one cycle after the triggering event; fail_o is a registered pulse.
// Backpressure: full_o throttles pushes; pop_i must only assert while send != tail.
// Ports: push/pop strobes, commit/retry requests in; send/tail/full/occupancy/fail out.
module retry_replay_ptrs
    import retry_pkg::*;
#(
    parameter int unsigned IDSize     = 4,
    parameter int unsigned MaxRetries = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              commit_vld_i,
    input  logic [IDSize-1:0] commit_id_i,
    input  logic              retry_vld_i,
    input  logic [IDSize-1:0] retry_id_i,
    output logic [IDSize:0]   send_o,
    output logic [IDSize:0]   tail_o,
    output logic              full_o,
    output logic [IDSize:0]   occupancy_o,
    output logic              fail_o,
    output logic [IDSize-1:0] fail_id_o
);

    localparam int unsigned PW = ptr_width(IDSize);
    localparam int unsigned CW = cnt_width(MaxRetries);
    localparam logic [PW-1:0] ONE     = PW'(1);
    localparam logic [PW-1:0] DEPTH_P = PW'(1) << IDSize;
    localparam logic [CW-1:0] CNT_MAX = CW'(MaxRetries);

    logic [PW-1:0]     head_q, head_d, send_q, send_d, tail_q, tail_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fail_q, fail_d;
    logic [IDSize-1:0] fail_id_q, fail_id_d;

    logic              empty;
    logic [PW-1:0]     occ;
    logic              commit_ok, retry_ok;
    logic [PW-1:0]     head_c;
    logic [CW-1:0]     cnt_c;
    retry_ev_e         ev;

    // Commit is resolved first; a retry then refers to the post-commit head.
    always_comb begin
        empty     = (head_q == tail_q);
        occ       = tail_q - head_q;
        commit_ok = commit_vld_i && !empty && (commit_id_i == head_q[IDSize-1:0]);
        head_c    = commit_ok ? head_q + ONE : head_q;
        cnt_c     = commit_ok ? '0 : cnt_q;
        retry_ok  = retry_vld_i && (head_c != tail_q) && (retry_id_i == head_c[IDSize-1:0]);
        ev        = EV_NONE;
        if (retry_ok) begin
            ev = (cnt_c < CNT_MAX) ? EV_RETRY : EV_FAIL;
        end
    end

    always_comb begin
        tail_d    = push_i ? tail_q + ONE : tail_q;
        head_d    = head_c;
        cnt_d     = cnt_c;
        send_d    = pop_i ? send_q + ONE : send_q;
        fail_d    = 1'b0;
        fail_id_d = fail_id_q;
        case (ev)
            EV_RETRY: begin
                // Go back to the head; any same-cycle downstream handshake is discarded.
                send_d = head_c;
                cnt_d  = cnt_c + CW'(1);
            end
            EV_FAIL: begin
                head_d    = head_c + ONE;
                send_d    = head_c + ONE;
                cnt_d     = '0;
                fail_d    = 1'b1;
                fail_id_d = head_c[IDSize-1:0];
            end
            default: ;
        endcase
        // A commit of an item not yet emitted would leave send behind head; pull it forward.
        if ((send_d - head_d) > (tail_d - head_d)) begin
            send_d = head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q    <= '0;
            send_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            fail_q    <= 1'b0;
            fail_id_q <= '0;
        end else begin
            head_q    <= head_d;
            send_q    <= send_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            fail_id_q <= fail_id_d;
        end
    end

    // Out-of-order or empty-buffer requests are dropped; flag them in simulation.
    always_ff @(posedge clk_i) begin
        if (rst_ni && commit_vld_i) begin
            assert (commit_ok)
            else $warning("commit id %0d ignored (head id %0d, empty %0b)",
                          commit_id_i, head_q[IDSize-1:0], empty);
        end
        if (rst_ni && retry_vld_i) begin
            assert (retry_ok)
            else $warning("retry id %0d ignored (head id %0d)", retry_id_i, head_c[IDSize-1:0]);
        end
    end

    assign send_o      = send_q;
    assign tail_o      = tail_q;
    assign occupancy_o = occ;
    assign full_o      = (occ == DEPTH_P);
    assign fail_o      = fail_q;
    assign fail_id_o   = fail_id_q;

endmodule

// File: rtl/retry_inorder_replay.sv
// Purpose: go-back-N replay buffer; holds items until in-order commit, replays from head on retry.
// Latency: one cycle from upstream accept to data_o; retry/fail visible on the next cycle.
// Backpressure: ready_o = !full (registered pointers only); data_o/valid_o held until ready_i.
// Ports: clk_i, rst_ni (sync, active-low), io (slave modport: upstream, downstream, commit/retry, status).
module retry_inorder_replay
    import retry_pkg::*;
#(
    parameter type         DataType   = logic [7:0],
    parameter int unsigned IDSize     = 4,
    parameter int unsigned MaxRetries = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    retry_inorder_replay_if.slave  io
);

    localparam int unsigned PW    = ptr_width(IDSize);
    localparam int unsigned Depth = 2 ** IDSize;

    logic [PW-1:0]     send, tail, occupancy;
    logic              full, push, pop, valid, fail;
    logic [IDSize-1:0] fail_id;
    logic              retry_ready_q, retry_ready_d;

    // Storage is not reset; pointers alone define which entries are live.
    DataType mem_q [Depth];

    assign valid = (send != tail);
    assign push  = io.valid_i && !full;
    assign pop   = valid && io.ready_i;

    retry_replay_ptrs #(
        .IDSize     (IDSize),
        .MaxRetries (MaxRetries)
    ) u_ptrs (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .pop_i        (pop),
        .commit_vld_i (io.commit_valid_i),
        .commit_id_i  (io.commit_id_i),
        .retry_vld_i  (io.retry_valid_i),
        .retry_id_i   (io.retry_id_i),
        .send_o       (send),
        .tail_o       (tail),
        .full_o       (full),
        .occupancy_o  (occupancy),
        .fail_o       (fail),
        .fail_id_o    (fail_id)
    );

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[tail[IDSize-1:0]] <= io.data_i;
        end
    end

    always_comb begin
        retry_ready_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            retry_ready_q <= 1'b0;
        end else begin
            retry_ready_q <= retry_ready_d;
        end
    end

    assign io.ready_o       = !full;
    assign io.valid_o       = valid;
    assign io.data_o        = mem_q[send[IDSize-1:0]];
    assign io.id_o          = send[IDSize-1:0];
    assign io.retry_ready_o = retry_ready_q;
    assign io.fail_o        = fail;
    assign io.fail_id_o     = fail_id;
    assign io.occupancy_o   = occupancy;

endmodule

// File: tb/tb_retry_inorder_replay.sv
// Purpose: directed and randomized checking of retry_inorder_replay against a queue-based model.
// Latency: model predicts outputs each cycle from the inputs applied the cycle before.
// Backpressure: bench randomizes upstream valid and downstream ready.
module tb_retry_inorder_replay;
    import retry_pkg::*;

    localparam int ID      = 4;
    localparam int DEPTH   = 16;
    localparam int MAXR    = 3;
    localparam int N_ITEMS = 10000;
    localparam int CYC_MAX = 80000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    retry_inorder_replay_if #(.DataType(logic [7:0]), .IDSize(ID)) bus ();

    retry_inorder_replay #(
        .DataType   (logic [7:0]),
        .IDSize     (ID),
        .MaxRetries (MAXR)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io     (bus)
    );

    typedef struct {
        logic [7:0] dat;
        int         id;
    } item_t;

    // Model: queue of uncommitted items, oldest first; m_send is the offset of the next item to emit.
    item_t mbuf[$];
    int    m_send, m_cnt, m_next_id, m_fail_id, m_done, m_fails, m_pushed;
    bit    m_fail;
    int    n_pass = 0;
    int    n_chk  = 0;
    int    n_dut_fails = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        mbuf.delete();
        m_send = 0; m_cnt = 0; m_next_id = 0; m_fail = 0; m_fail_id = 0;
        m_done = 0; m_fails = 0; m_pushed = 0;
    endfunction

    function automatic void model_step(input bit push, input logic [7:0] d, input bit rdy,
                                       input bit cv, input int cid, input bit rv, input int rid);
        bit do_push, do_pop, commit_ok, retry_ok;
        int hd, s;
        do_push   = push && (mbuf.size() < DEPTH);
        do_pop    = (m_send < mbuf.size()) && rdy;
        commit_ok = cv && (mbuf.size() > 0) && (cid == mbuf[0].id);
        hd        = commit_ok ? 1 : 0;
        retry_ok  = rv && (mbuf.size() > hd) && (rid == mbuf[hd].id);
        m_fail    = 0;
        if (commit_ok) begin
            void'(mbuf.pop_front());
            m_cnt = 0;
            m_done++;
        end
        if (retry_ok) begin
            if (m_cnt < MAXR) begin
                m_send = 0;
                m_cnt++;
            end else begin
                m_fail    = 1;
                m_fail_id = mbuf[0].id;
                void'(mbuf.pop_front());
                m_send = 0;
                m_cnt  = 0;
                m_done++;
                m_fails++;
            end
        end else begin
            s = m_send + (do_pop ? 1 : 0);
            if (commit_ok) s = (s > 0) ? s - 1 : 0;
            m_send = s;
        end
        if (do_push) begin
            mbuf.push_back('{dat: d, id: m_next_id});
            m_next_id = (m_next_id + 1) % DEPTH;
            m_pushed++;
        end
    endfunction

    task automatic check_outputs();
        bit v;
        v = (m_send < mbuf.size());
        chk("valid_o", bus.valid_o, v);
        if (v) begin
            chk("data_o", bus.data_o, mbuf[m_send].dat);
            chk("id_o", bus.id_o, mbuf[m_send].id);
        end
        chk("ready_o", bus.ready_o, (mbuf.size() < DEPTH));
        chk("occupancy_o", bus.occupancy_o, mbuf.size());
        chk("fail_o", bus.fail_o, m_fail);
        if (m_fail) chk("fail_id_o", bus.fail_id_o, m_fail_id);
        chk("retry_ready_o", bus.retry_ready_o, 1);
    endtask

    // Called at posedge+1: check current outputs, apply inputs for this cycle, advance one clock.
    task automatic tick(input bit push, input logic [7:0] d, input bit rdy,
                        input bit cv, input int cid, input bit rv, input int rid);
        if (bus.fail_o) n_dut_fails++;
        check_outputs();
        bus.valid_i        = push;
        bus.data_i         = d;
        bus.ready_i        = rdy;
        bus.commit_valid_i = cv;
        bus.commit_id_i    = 4'(cid);
        bus.retry_valid_i  = rv;
        bus.retry_id_i     = 4'(rid);
        model_step(push, d, rdy, cv, cid, rv, rid);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.valid_i        = 1'b0;
        bus.data_i         = '0;
        bus.ready_i        = 1'b0;
        bus.commit_valid_i = 1'b0;
        bus.commit_id_i    = '0;
        bus.retry_valid_i  = 1'b0;
        bus.retry_id_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_o", bus.valid_o, 0);
        chk("rst_ready_o", bus.ready_o, 1);
        chk("rst_occupancy_o", bus.occupancy_o, 0);
        chk("rst_fail_o", bus.fail_o, 0);
        chk("rst_retry_ready_o", bus.retry_ready_o, 0);
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         ids[$];
        logic [7:0] dats[$];
        logic [7:0] exp_d [3];
        exp_d = '{8'h11, 8'h22, 8'h33};

        // In-order push/emit/commit of three items.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bit cv;
            int cid;
            cv  = (mbuf.size() > 0) && (m_send > 0);
            cid = cv ? mbuf[0].id : 0;
            if (bus.valid_o) begin
                ids.push_back(int'(bus.id_o));
                dats.push_back(bus.data_o);
            end
            tick(i < 3, (i < 3) ? exp_d[i] : 8'h00, 1, cv, cid, 0, 0);
        end
        chk("p1_emit_count", ids.size(), 3);
        for (int i = 0; i < 3 && i < ids.size(); i++) begin
            chk("p1_id", ids[i], i);
            chk("p1_data", dats[i], exp_d[i]);
        end
        chk("p1_occ_zero", bus.occupancy_o, 0);

        // Fill to Depth with downstream stalled, then free one slot.
        do_reset();
        for (int k = 0; k < 16; k++) tick(1, 8'((k + 1) * 17), 0, 0, 0, 0, 0);
        chk("p2_ready_full", bus.ready_o, 0);
        chk("p2_occ_full", bus.occupancy_o, 16);
        tick(0, 8'h00, 0, 1, 0, 0, 0);
        chk("p2_ready_after_commit", bus.ready_o, 1);
        chk("p2_occ_after_commit", bus.occupancy_o, 15);

        // Emit 0..3, replay from head, then exhaust retries on ID 0.
        do_reset();
        for (int k = 0; k < 4; k++) tick(1, 8'((k + 1) * 17), 1, 0, 0, 0, 0);
        for (int k = 0; k < 4 && m_send < 4; k++) tick(0, 8'h00, 1, 0, 0, 0, 0);
        chk("p3_all_sent", bus.valid_o, 0);
        tick(0, 8'h00, 0, 0, 0, 1, 0);
        chk("p3_replay_valid", bus.valid_o, 1);
        chk("p3_replay_id0", bus.id_o, 0);
        chk("p3_replay_data", bus.data_o, 8'h11);
        for (int k = 0; k < 4; k++) begin
            chk("p3_replay_seq", bus.id_o, k);
            tick(0, 8'h00, 1, 0, 0, 0, 0);
        end
        for (int r = 0; r < 3; r++) tick(0, 8'h00, 0, 0, 0, 1, 0);
        chk("p3_fail_pulse", bus.fail_o, 1);
        chk("p3_fail_id", bus.fail_id_o, 0);
        chk("p3_next_id", bus.id_o, 1);
        chk("p3_occ", bus.occupancy_o, 3);

        // Commit of head 5 together with retry of 6; then a stray retry for 9.
        do_reset();
        for (int k = 0; k < 12; k++) tick(k < 8, 8'(k + 1), 1, 0, 0, 0, 0);
        chk("p4_all_sent", bus.valid_o, 0);
        for (int k = 0; k < 5; k++) tick(0, 8'h00, 0, 1, k, 0, 0);
        tick(0, 8'h00, 0, 1, 5, 1, 6);
        chk("p4_send_at_6", bus.id_o, 6);
        chk("p4_valid", bus.valid_o, 1);
        chk("p4_occ", bus.occupancy_o, 2);
        tick(0, 8'h00, 1, 0, 0, 0, 0);
        chk("p4_emit_7", bus.id_o, 7);
        tick(0, 8'h00, 0, 0, 0, 1, 9);
        chk("p4_stray_retry_ignored", bus.id_o, 7);
        chk("p4_occ_unchanged", bus.occupancy_o, 2);

        // Randomized traffic with periodic retries and occasional retry bursts that exhaust MaxRetries.
        do_reset();
        n_dut_fails = 0;
        begin
            int cyc, timer, burst;
            cyc   = 0;
            timer = $urandom_range(20, 15);
            burst = 0;
            while (m_done < N_ITEMS && cyc < CYC_MAX) begin
                bit         push, rdy, cv, rv;
                int         cid, rid;
                logic [7:0] d;
                push = (m_pushed < N_ITEMS) && ($urandom_range(9, 0) < 9);
                d    = 8'($urandom);
                rdy  = ($urandom_range(9, 0) < 9);
                cv = 0; rv = 0; cid = 0; rid = 0;
                if (burst > 0) begin
                    burst--;
                    if (mbuf.size() > 0) begin
                        rv  = 1;
                        rid = mbuf[0].id;
                    end else begin
                        burst = 0;
                    end
                end else if (timer == 0) begin
                    timer = $urandom_range(20, 15);
                    if (mbuf.size() > 0) begin
                        rv = 1;
                        if (mbuf.size() > 1 && $urandom_range(2, 0) == 0) begin
                            cv  = 1;
                            cid = mbuf[0].id;
                            rid = mbuf[1].id;
                        end else begin
                            rid = mbuf[0].id;
                        end
                        if ($urandom_range(3, 0) == 0) burst = 3;
                    end
                end else begin
                    timer--;
                    if (mbuf.size() > 0 && m_send > 0 && $urandom_range(9, 0) < 8) begin
                        cv  = 1;
                        cid = mbuf[0].id;
                    end
                end
                tick(push, d, rdy, cv, cid, rv, rid);
                cyc++;
            end
            tick(0, 8'h00, 0, 0, 0, 0, 0);
            chk("rand_all_retired", m_done, N_ITEMS);
            chk("rand_fail_pulses", n_dut_fails, m_fails);
            chk("rand_fails_exercised", (m_fails > 0), 1);
            chk("rand_occ_drained", bus.occupancy_o, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
